// File: rtl/zxspi_master_if.sv
// zxspi_master_if: host-side bus between the Z80 port-decode/DMA logic
// and the SD card SPI master.
//
// Signals:
//   clk_div   - SCK half-period minus 1, in clk_peripheral cycles
//   tx_data   - byte to transmit
//   start     - transfer request (taken only while busy is low)
//   cs_assert - 1 selects the card (enable_n driven low)
//   rx_data   - last received byte, valid from the done pulse onward
//   busy      - transfer in progress
//   done      - one-cycle pulse when rx_data has just been updated
//
// Modports:
//   master - the host that issues transfers
//   slave  - the SPI master block that serves them
interface zxspi_master_if #(
    parameter int DIV_BITS = 8
) ();
    logic [DIV_BITS-1:0] clk_div;
    logic [7:0]          tx_data;
    logic                start;
    logic                cs_assert;
    logic [7:0]          rx_data;
    logic                busy;
    logic                done;

    modport master (
        output clk_div, tx_data, start, cs_assert,
        input  rx_data, busy, done
    );

    modport slave (
        input  clk_div, tx_data, start, cs_assert,
        output rx_data, busy, done
    );
endinterface

// File: rtl/zxspi_master.sv
// zxspi_master: byte-wide SPI mode-0 master for the SD card path.
// Each accepted start shifts one byte out MSB-first on spi_mosi while
// sampling spi_miso on every SCK rising edge, then pulses done with the
// received byte on rx_data.
//
// Ports:
//   clk_peripheral - system clock, all state changes on its rising edge
//   reset          - asynchronous, active-high reset
//   bus            - host handshake (zxspi_master_if.slave)
//   spi_sck        - SPI clock, idles low
//   spi_mosi       - SPI data out, idles high
//   spi_miso       - SPI data in
//   enable_n       - active-low card select, changes only between bytes
module zxspi_master #(
    parameter int DIV_BITS = 8
) (
    input  logic                 clk_peripheral,
    input  logic                 reset,
    zxspi_master_if.slave        bus,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 enable_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          phase, phase_nxt;
    logic [DIV_BITS-1:0] cnt, cnt_nxt;
    logic [DIV_BITS-1:0] div_l, div_nxt;
    logic [6:0]          tx_sr, tx_nxt;
    logic [7:0]          rx_sr, rx_nxt;
    logic [7:0]          rx_data_q, rx_data_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                sck_nxt, mosi_nxt, en_nxt;

    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Register bank. Every output is registered so SCK, MOSI and the
    // card select are glitch-free at the card.
    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 4'd0;
            cnt       <= '0;
            div_l     <= '0;
            tx_sr     <= 7'd0;
            rx_sr     <= 8'd0;
            rx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b1;
            enable_n  <= 1'b1;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            div_l     <= div_nxt;
            tx_sr     <= tx_nxt;
            rx_sr     <= rx_nxt;
            rx_data_q <= rx_data_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            spi_sck   <= sck_nxt;
            spi_mosi  <= mosi_nxt;
            enable_n  <= en_nxt;
        end
    end

    // Next-state and output logic. A byte is 16 SCK half-periods (phases);
    // even phases have SCK low, odd phases SCK high. The down-counter runs
    // through each phase and reloads the latched divider at the boundary,
    // where SCK toggles. FINISH behaves like IDLE so a new byte can start
    // on the done cycle with only that single cycle of gap.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        cnt_nxt     = cnt;
        div_nxt     = div_l;
        tx_nxt      = tx_sr;
        rx_nxt      = rx_sr;
        rx_data_nxt = rx_data_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        sck_nxt     = spi_sck;
        mosi_nxt    = spi_mosi;
        en_nxt      = enable_n;

        case (state)
            IDLE, FINISH: begin
                state_nxt = IDLE;
                en_nxt    = ~bus.cs_assert;
                if (bus.start) begin
                    state_nxt = SHIFT;
                    phase_nxt = 4'd0;
                    cnt_nxt   = bus.clk_div;
                    div_nxt   = bus.clk_div;
                    tx_nxt    = bus.tx_data[6:0];
                    mosi_nxt  = bus.tx_data[7];
                    busy_nxt  = 1'b1;
                end
            end

            SHIFT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DIV_BITS'(1);
                end else if (phase == 4'd15) begin
                    // Final falling edge: release the line and publish the byte.
                    state_nxt   = FINISH;
                    sck_nxt     = 1'b0;
                    mosi_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    rx_data_nxt = rx_sr;
                end else begin
                    phase_nxt = phase + 4'd1;
                    cnt_nxt   = div_l;
                    sck_nxt   = ~spi_sck;
                    if (!phase[0]) begin
                        // Rising edge: the card's bit is stable, capture it.
                        rx_nxt = {rx_sr[6:0], spi_miso};
                    end else begin
                        // Falling edge: present the next transmit bit.
                        mosi_nxt = tx_sr[6];
                        tx_nxt   = {tx_sr[5:0], 1'b0};
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_zxspi_master.sv
// tb_zxspi_master: self-checking bench for zxspi_master.
// A cycle-level reference model derives SCK, MOSI, busy, done, rx_data and
// enable_n from the elapsed cycle count of the current byte; a compare
// process checks every output on every falling clock edge, and directed
// scenarios add hand-computed literal expectations.
module tb_zxspi_master;

    localparam int DIV_BITS = 8;
    localparam int MISO_RAND = 0;
    localparam int MISO_ONE  = 1;
    localparam int MISO_PAT  = 2;
    localparam int MISO_LOOP = 3;

    logic clk;
    logic reset;
    logic spi_sck, spi_mosi, spi_miso, enable_n;
    logic miso_drv;
    int   miso_mode;
    logic [7:0] miso_pattern;

    int checks;
    int failures;
    bit chk_en;

    // Reference model state
    bit         m_busy;
    bit         m_done;
    int         m_n;
    int         m_d;
    logic [7:0] m_tx;
    logic [7:0] m_rx;
    logic [7:0] m_rx_data;
    logic       m_en;

    // Observation counters
    int   sck_rises;
    int   en_low_cycles;
    int   done_pulses;
    logic prev_sck;

    zxspi_master_if #(.DIV_BITS(DIV_BITS)) bus ();

    zxspi_master #(.DIV_BITS(DIV_BITS)) dut (
        .clk_peripheral (clk),
        .reset          (reset),
        .bus            (bus),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .enable_n       (enable_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign spi_miso = (miso_mode == MISO_LOOP) ? spi_mosi : miso_drv;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte lasts 16 half-periods of (D+1) cycles, MISO is
    // captured in the last cycle of every even half-period, and the done
    // cycle follows the last one. Start is only honoured when not busy.
    always @(posedge clk or posedge reset) begin
        int len;
        int k;
        if (reset) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_n       = 0;
            m_d       = 0;
            m_tx      = 8'h00;
            m_rx      = 8'h00;
            m_rx_data = 8'h00;
            m_en      = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                len = m_d + 1;
                k   = m_n / len;
                if ((m_n % len) == len - 1 && (k % 2) == 0)
                    m_rx = {m_rx[6:0], spi_miso};
                if (m_n == 16 * len - 1) begin
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    m_rx_data = m_rx;
                end else begin
                    m_n++;
                end
            end else begin
                m_en = ~bus.cs_assert;
                if (bus.start) begin
                    m_busy = 1'b1;
                    m_n    = 0;
                    m_d    = int'(bus.clk_div);
                    m_tx   = bus.tx_data;
                end
            end
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        int   k;
        logic e_sck;
        logic e_mosi;
        if (chk_en && !reset) begin
            k      = m_busy ? m_n / (m_d + 1) : 0;
            e_sck  = m_busy ? logic'(k % 2) : 1'b0;
            e_mosi = m_busy ? m_tx[7 - k / 2] : 1'b1;
            checkOutput("sck", 32'(spi_sck), 32'(e_sck));
            checkOutput("mosi", 32'(spi_mosi), 32'(e_mosi));
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            checkOutput("done", 32'(bus.done), 32'(m_done));
            checkOutput("rx_data", 32'(bus.rx_data), 32'(m_rx_data));
            checkOutput("enable_n", 32'(enable_n), 32'(m_en));
        end
    end

    // MISO source for the non-loopback modes.
    always @(negedge clk) begin
        case (miso_mode)
            MISO_RAND: miso_drv = 1'($urandom_range(0, 1));
            MISO_ONE:  miso_drv = 1'b1;
            MISO_PAT:  if (m_busy) miso_drv = miso_pattern[7 - (m_n / (m_d + 1)) / 2];
            default:   miso_drv = 1'b1;
        endcase
    end

    // Event counters used by the directed scenarios.
    always @(negedge clk) begin
        if (spi_sck === 1'b1 && prev_sck === 1'b0) sck_rises++;
        if (enable_n === 1'b0) en_low_cycles++;
        if (bus.done === 1'b1) done_pulses++;
        prev_sck = spi_sck;
    end

    // Drive a start request on the current falling edge; returns on the
    // falling edge of the first busy cycle.
    task automatic issueStart(input logic [7:0] div, input logic [7:0] tx, input logic cs);
        bus.clk_div   = div;
        bus.tx_data   = tx;
        bus.cs_assert = cs;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] div, input logic [7:0] tx, input logic cs);
        @(negedge clk);
        issueStart(div, tx, cs);
    endtask

    // Counts cycles (first busy cycle = 1) until done is seen, bounded.
    task automatic waitDone(input int limit, output int cnt);
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        if (bus.done !== 1'b1) cnt = -1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int base_rises, base_en, base_done;
        logic [7:0] tx;
        logic [7:0] dv;

        checks        = 0;
        failures      = 0;
        chk_en        = 1'b0;
        sck_rises     = 0;
        en_low_cycles = 0;
        done_pulses   = 0;
        prev_sck      = 1'b0;
        miso_mode     = MISO_ONE;
        miso_drv      = 1'b1;
        miso_pattern  = 8'h00;
        bus.clk_div   = '0;
        bus.tx_data   = 8'h00;
        bus.start     = 1'b0;
        bus.cs_assert = 1'b0;
        reset         = 1'b1;

        #22;
        checkOutput("rst_sck", 32'(spi_sck), 32'd0);
        checkOutput("rst_mosi", 32'(spi_mosi), 32'd1);
        checkOutput("rst_enable_n", 32'(enable_n), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 32'h00);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback, fastest SCK, card selected
        $display("[TB] loopback D=0 tx=A5");
        miso_mode  = MISO_LOOP;
        base_rises = sck_rises;
        applyStimulus(8'd0, 8'hA5, 1'b1);
        checkOutput("t1_enable_n", 32'(enable_n), 32'd0);
        waitDone(100, cnt);
        checkOutput("t1_latency", 32'(cnt), 32'd17);
        checkOutput("t1_rx", 32'(bus.rx_data), 32'hA5);
        @(negedge clk);
        checkOutput("t1_mosi_idle", 32'(spi_mosi), 32'd1);
        @(negedge clk);
        checkOutput("t1_sck_pulses", 32'(sck_rises - base_rises), 32'd8);

        // D=3, MISO tied high
        $display("[TB] D=3 tx=3C miso=1");
        miso_mode  = MISO_ONE;
        base_rises = sck_rises;
        applyStimulus(8'd3, 8'h3C, 1'b1);
        waitDone(200, cnt);
        checkOutput("t2_latency", 32'(cnt), 32'd65);
        checkOutput("t2_rx", 32'(bus.rx_data), 32'hFF);
        repeat (2) @(negedge clk);
        checkOutput("t2_sck_pulses", 32'(sck_rises - base_rises), 32'd8);

        // Ten back-to-back idle bytes, card deselected
        $display("[TB] ten back-to-back 0xFF bytes");
        bus.cs_assert = 1'b0;
        repeat (3) @(negedge clk);
        base_rises = sck_rises;
        base_en    = en_low_cycles;
        issueStart(8'd0, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            waitDone(100, cnt);
            checkOutput("t3_latency", 32'(cnt), 32'd17);
            if (i < 9) issueStart(8'd0, 8'hFF, 1'b0);
        end
        repeat (2) @(negedge clk);
        checkOutput("t3_sck_pulses", 32'(sck_rises - base_rises), 32'd80);
        checkOutput("t3_enable_low", 32'(en_low_cycles - base_en), 32'd0);

        // Restart attempt and card-select change mid-transfer
        $display("[TB] start and cs_assert during transfer");
        miso_mode = MISO_RAND;
        base_done = done_pulses;
        applyStimulus(8'd1, 8'hC3, 1'b1);
        repeat (5) @(negedge clk);
        bus.start     = 1'b1;
        bus.cs_assert = 1'b0;
        bus.tx_data   = 8'h00;
        bus.clk_div   = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(200, cnt);
        checkOutput("t4_latency", 32'(cnt), 32'd27);
        checkOutput("t4_enable_n_at_done", 32'(enable_n), 32'd0);
        @(negedge clk);
        checkOutput("t4_enable_n_after", 32'(enable_n), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t4_done_pulses", 32'(done_pulses - base_done), 32'd1);

        // Asynchronous reset during phase 9
        $display("[TB] reset during phase 9");
        bus.cs_assert = 1'b1;
        base_done     = done_pulses;
        applyStimulus(8'd1, 8'h96, 1'b1);
        repeat (18) @(negedge clk);
        checkOutput("t5_sck_phase9", 32'(spi_sck), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_sck", 32'(spi_sck), 32'd0);
        checkOutput("t5_mosi", 32'(spi_mosi), 32'd1);
        checkOutput("t5_enable_n", 32'(enable_n), 32'd1);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("t5_no_done", 32'(done_pulses - base_done), 32'd0);
        miso_mode = MISO_LOOP;
        applyStimulus(8'd2, 8'h5C, 1'b1);
        waitDone(200, cnt);
        checkOutput("t5_latency", 32'(cnt), 32'd49);
        checkOutput("t5_rx", 32'(bus.rx_data), 32'h5C);

        // Slowest divider with patterned MISO
        $display("[TB] D=FF tx=81 miso pattern 5A");
        miso_mode    = MISO_PAT;
        miso_pattern = 8'h5A;
        applyStimulus(8'hFF, 8'h81, 1'b1);
        waitDone(5000, cnt);
        checkOutput("t6_latency", 32'(cnt), 32'd4097);
        checkOutput("t6_rx", 32'(bus.rx_data), 32'h5A);

        // Randomized transfers checked by the model
        $display("[TB] randomized transfers");
        miso_mode = MISO_RAND;
        for (int i = 0; i < 30; i++) begin
            dv = 8'($urandom_range(0, 4));
            tx = 8'($urandom);
            applyStimulus(dv, tx, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                bus.start     = 1'b1;
                bus.cs_assert = 1'($urandom_range(0, 1));
                bus.clk_div   = 8'($urandom);
                @(negedge clk);
                bus.start = 1'b0;
                waitDone(300, cnt);
                checkOutput("rand_done_seen", 32'(cnt > 0), 32'd1);
            end else begin
                waitDone(300, cnt);
                checkOutput("rand_latency", 32'(cnt), 32'(16 * (int'(dv) + 1) + 1));
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
